// File: rtl/acc_pkg.sv
// Shared constants and types for the image accelerators.
//   IMG_W / IMG_H        : image size in pixels (8-bit pixels)
//   WORDS_PER_ROW        : 32-bit words per image row (4 pixels per word)
//   IMG_WORDS            : words per full image
//   sobel_state_e        : acc_sobel control states
package acc_pkg;

   localparam int IMG_W         = 352;
   localparam int IMG_H         = 288;
   localparam int WORDS_PER_ROW = IMG_W / 4;
   localparam int IMG_WORDS     = WORDS_PER_ROW * IMG_H;

   typedef enum logic [3:0] {
      IDLE,
      ZWR,
      PRE0,
      PRE1,
      PRE2,
      PRE3,
      FET0,
      FET1,
      FET2,
      FET3,
      WR,
      DONE
   } sobel_state_e;

endpackage

// File: rtl/sobel_px.sv
// Sobel gradient magnitude for one pixel.
//   p00..p22 : 3x3 neighbourhood, row-major (p<row><col>), row 0 = y-1, col 0 = x-1
//   mag      : (|Dx| + |Dy|) >> 3
// Purely combinational.
module sobel_px (
   input  logic [7:0] p00,
   input  logic [7:0] p01,
   input  logic [7:0] p02,
   input  logic [7:0] p10,
   input  logic [7:0] p11,
   input  logic [7:0] p12,
   input  logic [7:0] p20,
   input  logic [7:0] p21,
   input  logic [7:0] p22,
   output logic [7:0] mag
);

   function automatic logic signed [10:0] widen(input logic [7:0] v);
      return signed'({3'b000, v});
   endfunction

   function automatic logic [10:0] abs_val(input logic signed [10:0] v);
      return (v < 0) ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Sum of magnitudes is at most 2040, so dropping three LSBs always fits 8 bits.
   function automatic logic [7:0] scale(input logic [10:0] s);
      return 8'(s >> 3);
   endfunction

   logic signed [10:0] dx;
   logic signed [10:0] dy;
   logic        [10:0] sum;

   // The centre tap has zero weight in both kernels.
   logic unused_p11;
   assign unused_p11 = ^p11;

   always_comb begin
      dx  = (widen(p02) + (widen(p12) <<< 1) + widen(p22))
          - (widen(p00) + (widen(p10) <<< 1) + widen(p20));
      dy  = (widen(p20) + (widen(p21) <<< 1) + widen(p22))
          - (widen(p00) + (widen(p01) <<< 1) + widen(p02));
      sum = abs_val(dx) + abs_val(dy);
      mag = scale(sum);
   end

endmodule

// File: rtl/acc_sobel.sv
// Sobel edge-detection accelerator on a shared 16-bit word-addressed memory.
//   clk, reset     : clock, synchronous active-high reset
//   addr           : memory word address
//   dataR          : read data, valid the cycle after a read request
//   dataW          : write data
//   en, we         : memory request / write enable
//   start, finish  : level run request / run complete
// Reads the source image at SRC_BASE, writes the edge image at DST_BASE.
// Outputs are decoded from registered state only.
module acc_sobel
   import acc_pkg::*;
#(
   parameter logic [15:0] SRC_BASE  = 16'(IMG_WORDS),
   parameter logic [15:0] DST_BASE  = 16'd0,
   parameter int          ROW_WORDS = WORDS_PER_ROW,
   parameter int          ROWS      = IMG_H
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] addr,
   input  logic [31:0] dataR,
   output logic [31:0] dataW,
   output logic        en,
   output logic        we,
   input  logic        start,
   output logic        finish
);

   localparam logic [6:0]  LAST_C     = 7'(ROW_WORDS - 1);
   localparam logic [6:0]  PEN_C      = 7'(ROW_WORDS - 2);
   localparam logic [8:0]  LAST_INT_Y = 9'(ROWS - 2);
   localparam logic [15:0] ROW_STRIDE = 16'(ROW_WORDS);

   function automatic logic [15:0] word_addr(input logic [15:0] base,
                                             input logic [8:0]  row,
                                             input logic [6:0]  col);
      return base + 16'({7'd0, row} * ROW_STRIDE) + {9'd0, col};
   endfunction

   sobel_state_e state, state_nxt;
   logic [8:0]   y;
   logic [6:0]   c;

   // Only the last pixel of the previous word and the first pixel of the
   // next word enter the kernels; the next word is kept whole because it
   // becomes the current word.
   logic [2:0][7:0]  win_prev;
   logic [2:0][31:0] win_cur;
   logic [2:0][31:0] win_next;
   logic [2:0][47:0] line;
   logic [3:0][7:0]  px_mag;
   logic [31:0]      sobel_word;

   for (genvar r = 0; r < 3; r++) begin : g_line
      assign line[r] = {win_next[r][7:0], win_cur[r], win_prev[r]};
   end

   // line index 0 = previous pixel, 1..4 = current word, 5 = next pixel.
   for (genvar j = 0; j < 4; j++) begin : g_px
      sobel_px u_px (
         .p00 (line[0][8*j +: 8]),
         .p01 (line[0][8*(j+1) +: 8]),
         .p02 (line[0][8*(j+2) +: 8]),
         .p10 (line[1][8*j +: 8]),
         .p11 (line[1][8*(j+1) +: 8]),
         .p12 (line[1][8*(j+2) +: 8]),
         .p20 (line[2][8*j +: 8]),
         .p21 (line[2][8*(j+1) +: 8]),
         .p22 (line[2][8*(j+2) +: 8]),
         .mag (px_mag[j])
      );
   end

   always_comb begin
      sobel_word = px_mag;
      if (c == 7'd0)   sobel_word[7:0]   = 8'h00;
      if (c == LAST_C) sobel_word[31:24] = 8'h00;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr      = 16'd0;
      dataW     = 32'd0;
      en        = 1'b0;
      we        = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = ZWR;
         ZWR: begin
            en   = 1'b1;
            we   = 1'b1;
            addr = word_addr(DST_BASE, y, c);
            if (c == LAST_C) state_nxt = (y == 9'd0) ? PRE0 : DONE;
         end
         PRE0: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y - 9'd1, 7'd0); state_nxt = PRE1;
         end
         PRE1: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y, 7'd0); state_nxt = PRE2;
         end
         PRE2: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y + 9'd1, 7'd0); state_nxt = PRE3;
         end
         PRE3: state_nxt = FET0;
         FET0: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y - 9'd1, c + 7'd1); state_nxt = FET1;
         end
         FET1: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y, c + 7'd1); state_nxt = FET2;
         end
         FET2: begin
            en = 1'b1; addr = word_addr(SRC_BASE, y + 9'd1, c + 7'd1); state_nxt = FET3;
         end
         FET3: state_nxt = WR;
         WR: begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = word_addr(DST_BASE, y, c);
            dataW = sobel_word;
            if (c == LAST_C)     state_nxt = (y == LAST_INT_Y) ? ZWR : PRE0;
            // The last column has no right-hand word to fetch.
            else if (c == PEN_C) state_nxt = WR;
            else                 state_nxt = FET0;
         end
         DONE: begin
            finish = 1'b1;
            if (!start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y <= 9'd0;
         c <= 7'd0;
      end else begin
         case (state)
            IDLE: if (start) begin
               y <= 9'd0;
               c <= 7'd0;
            end
            ZWR: begin
               if (c == LAST_C) begin
                  c <= 7'd0;
                  if (y == 9'd0) y <= 9'd1;
               end else begin
                  c <= c + 7'd1;
               end
            end
            WR: begin
               if (c == LAST_C) begin
                  c <= 7'd0;
                  y <= y + 9'd1;
               end else begin
                  c <= c + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Each read is captured one state after it is issued.
   always_ff @(posedge clk) begin
      case (state)
         PRE0: win_prev    <= '0;
         PRE1: win_cur[0]  <= dataR;
         PRE2: win_cur[1]  <= dataR;
         PRE3: win_cur[2]  <= dataR;
         FET1: win_next[0] <= dataR;
         FET2: win_next[1] <= dataR;
         FET3: win_next[2] <= dataR;
         WR: begin
            for (int r = 0; r < 3; r++) win_prev[r] <= win_cur[r][31:24];
            win_cur  <= win_next;
            win_next <= '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_acc_sobel.sv
module tb_acc_sobel;

   localparam int WPR     = 8;
   localparam int ROWS    = 12;
   localparam int W       = WPR * 4;
   localparam int WORDS   = WPR * ROWS;
   localparam int SRC     = WORDS;
   localparam int DST     = 0;
   localparam int EXP_CYC = 2 * WPR + (ROWS - 2) * (5 * WPR);
   localparam int EXP_RD  = (ROWS - 2) * 3 * WPR;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] addr;
   logic [31:0] dataR;
   logic [31:0] dataW;
   logic        en;
   logic        we;
   logic        finish;

   always #5 clk = ~clk;

   acc_sobel #(
      .SRC_BASE  (16'(SRC)),
      .DST_BASE  (16'(DST)),
      .ROW_WORDS (WPR),
      .ROWS      (ROWS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .dataR  (dataR),
      .dataW  (dataW),
      .en     (en),
      .we     (we),
      .start  (start),
      .finish (finish)
   );

   int          pix [ROWS][W];
   logic [31:0] src_mem [WORDS];
   logic [31:0] dst_mem [WORDS];
   logic [47:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   // Memory: read data one cycle after request, write commits at the edge.
   always @(posedge clk) begin
      if (en === 1'b1 && we === 1'b0) begin
         if (int'(addr) >= SRC && int'(addr) < SRC + WORDS) dataR <= src_mem[int'(addr) - SRC];
         else                                              dataR <= 32'hA5A5A5A5;
      end
      if (en === 1'b1 && we === 1'b1 && int'(addr) >= DST && int'(addr) < DST + WORDS)
         dst_mem[int'(addr) - DST] <= dataW;
   end

   function automatic int sob(input int yy, input int xx);
      int dx, dy;
      dx = (pix[yy-1][xx+1] + 2*pix[yy][xx+1] + pix[yy+1][xx+1])
         - (pix[yy-1][xx-1] + 2*pix[yy][xx-1] + pix[yy+1][xx-1]);
      dy = (pix[yy+1][xx-1] + 2*pix[yy+1][xx] + pix[yy+1][xx+1])
         - (pix[yy-1][xx-1] + 2*pix[yy-1][xx] + pix[yy-1][xx+1]);
      return ((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy)) >> 3;
   endfunction

   // Fill the source image and push the expected write stream.
   task automatic build_image(input int pat);
      logic [31:0] w, e;
      int x;
      for (int yy = 0; yy < ROWS; yy++)
         for (int xx = 0; xx < W; xx++)
            case (pat)
               0:       pix[yy][xx] = 8'h80;
               1:       pix[yy][xx] = (xx < W/2) ? 0 : 255;
               2:       pix[yy][xx] = (yy < ROWS/2) ? 0 : 255;
               3:       pix[yy][xx] = (yy == 5 && xx == 5) ? 255 : 0;
               default: pix[yy][xx] = int'($urandom_range(0, 255));
            endcase
      for (int yy = 0; yy < ROWS; yy++)
         for (int cc = 0; cc < WPR; cc++) begin
            w = '0;
            e = '0;
            for (int j = 0; j < 4; j++) begin
               x = 4*cc + j;
               w[8*j +: 8] = 8'(pix[yy][x]);
               if (yy > 0 && yy < ROWS-1 && x > 0 && x < W-1) e[8*j +: 8] = 8'(sob(yy, x));
            end
            src_mem[yy*WPR + cc] = w;
            exp_q.push_back({16'(DST + yy*WPR + cc), e});
         end
   endtask

   // Raise start and follow the run; writes are scored as they appear.
   task automatic do_run(input int reset_at, output int fin_cyc, output int nwr, output int nrd);
      logic [47:0] e;
      start   = 1'b1;
      fin_cyc = 0;
      nwr     = 0;
      nrd     = 0;
      for (int k = 1; k <= EXP_CYC + 50; k++) begin
         @(posedge clk); #1;
         if (finish === 1'b1) begin
            fin_cyc = k;
            break;
         end
         if (en === 1'b1 && we === 1'b1) begin
            nwr++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_extra: addr=%h data=%h, no write expected", addr, dataW);
            end else begin
               e = exp_q.pop_front();
               if ({addr, dataW} !== e) begin
                  errors++;
                  $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                           addr, dataW, e[47:32], e[31:0]);
               end
            end
         end else if (en === 1'b1 && we === 1'b0) begin
            nrd++;
            checks++;
            if (int'(addr) < SRC || int'(addr) >= SRC + WORDS) begin
               errors++;
               $display("FAIL rd_range: addr=%h outside source %0d..%0d", addr, SRC, SRC+WORDS-1);
            end
         end
         if (k == reset_at) begin
            reset = 1'b1;
            start = 1'b0;
            break;
         end
      end
   endtask

   task automatic run_full_image(input int pat);
      int fc, nw, nr;
      build_image(pat);
      do_run(0, fc, nw, nr);
      checks++;
      if (fc != EXP_CYC + 1) begin
         errors++;
         $display("FAIL finish_cycle: got %0d, expected %0d (0 = timeout)", fc, EXP_CYC + 1);
      end
      checks++;
      if (nw != WORDS) begin
         errors++;
         $display("FAIL write_count: got %0d, expected %0d", nw, WORDS);
      end
      checks++;
      if (nr != EXP_RD) begin
         errors++;
         $display("FAIL read_count: got %0d, expected %0d", nr, EXP_RD);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: %0d expected writes never seen", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic end_run();
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({en, we, finish} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: en/we/finish=%b, expected 000", {en, we, finish});
      end
      checks++;
      if (addr !== 16'd0 || dataW !== 32'd0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h dataW=%h, expected 0", addr, dataW);
      end
      reset = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (en !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: en=%b, expected 0", en);
         end
      end
   endtask

   task automatic test_constant();
      run_full_image(0);
      end_run();
   endtask

   task automatic test_vertical_step();
      run_full_image(1);
      checks++;
      if (dst_mem[3*WPR + WPR/2 - 1] !== 32'h7F000000) begin
         errors++;
         $display("FAIL vstep_left: got %h, expected 7f000000", dst_mem[3*WPR + WPR/2 - 1]);
      end
      checks++;
      if (dst_mem[3*WPR + WPR/2] !== 32'h0000007F) begin
         errors++;
         $display("FAIL vstep_right: got %h, expected 0000007f", dst_mem[3*WPR + WPR/2]);
      end
      end_run();
   endtask

   task automatic test_horizontal_step();
      run_full_image(2);
      checks++;
      if (dst_mem[(ROWS/2 - 1)*WPR] !== 32'h7F7F7F00) begin
         errors++;
         $display("FAIL hstep_first: got %h, expected 7f7f7f00", dst_mem[(ROWS/2 - 1)*WPR]);
      end
      checks++;
      if (dst_mem[(ROWS/2)*WPR + 1] !== 32'h7F7F7F7F) begin
         errors++;
         $display("FAIL hstep_mid: got %h, expected 7f7f7f7f", dst_mem[(ROWS/2)*WPR + 1]);
      end
      checks++;
      if (dst_mem[(ROWS/2)*WPR + WPR - 1] !== 32'h007F7F7F) begin
         errors++;
         $display("FAIL hstep_last: got %h, expected 007f7f7f", dst_mem[(ROWS/2)*WPR + WPR - 1]);
      end
      end_run();
   endtask

   task automatic test_impulse();
      run_full_image(3);
      checks++;
      if (dst_mem[4*WPR + 1] !== 32'h003F3F3F) begin
         errors++;
         $display("FAIL impulse_above: got %h, expected 003f3f3f", dst_mem[4*WPR + 1]);
      end
      checks++;
      if (dst_mem[5*WPR + 1] !== 32'h003F003F) begin
         errors++;
         $display("FAIL impulse_centre: got %h, expected 003f003f", dst_mem[5*WPR + 1]);
      end
      checks++;
      if (dst_mem[6*WPR + 1] !== 32'h003F3F3F) begin
         errors++;
         $display("FAIL impulse_below: got %h, expected 003f3f3f", dst_mem[6*WPR + 1]);
      end
      end_run();
   endtask

   task automatic test_random();
      run_full_image(4);
      end_run();
   endtask

   task automatic test_midrun_reset();
      int fc, nw, nr;
      build_image(4);
      do_run(100, fc, nw, nr);
      @(posedge clk); #1;
      checks++;
      if ({en, we, finish} !== 3'b000 || addr !== 16'd0 || dataW !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset: en/we/finish=%b addr=%h dataW=%h, expected all 0",
                  {en, we, finish}, addr, dataW);
      end
      reset = 1'b0;
      exp_q.delete();
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (en !== 1'b0) begin
            errors++;
            $display("FAIL after_abort: en=%b, expected 0", en);
         end
      end
      run_full_image(1);
      end_run();
   endtask

   task automatic test_handshake();
      run_full_image(2);
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (finish !== 1'b1) begin
            errors++;
            $display("FAIL finish_hold: finish=%b, expected 1", finish);
         end
      end
      start = 1'b0;
      #1;
      checks++;
      if (finish !== 1'b1) begin
         errors++;
         $display("FAIL finish_registered: finish=%b, expected 1", finish);
      end
      @(posedge clk); #1;
      checks++;
      if (finish !== 1'b0 || en !== 1'b0) begin
         errors++;
         $display("FAIL finish_drop: finish=%b en=%b, expected 0 0", finish, en);
      end
      run_full_image(2);
      end_run();
   endtask

   initial begin
      start = 1'b0;
      reset = 1'b1;
      test_reset();
      test_constant();
      test_vertical_step();
      test_horizontal_step();
      test_impulse();
      test_random();
      test_midrun_reset();
      test_handshake();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/acc_sobel.md
# acc_sobel

Sobel edge-detection accelerator. It runs downstream of the inversion accelerator `acc0` on the same 16-bit-word-addressed memory. It reads the 352×288 8-bit image that `acc0` produced at word 25344 onward, computes the Sobel gradient magnitude for every pixel, and writes the edge image back to word 0 onward. It shares `acc0`'s memory port protocol and start/finish handshake, so the top level can sequence the two blocks on one bus.

## Interface
- `SRC_BASE`, default 25344: word address of source image row 0, word 0.
- `DST_BASE`, default 0: word address of result image row 0, word 0.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` out 16: memory word address.
- `dataR` in 32: read data, valid the cycle after the request.
- `dataW` out 32: write data.
- `en` out 1: memory request.
- `we` out 1: 1 = write, 0 = read; meaningful only when `en` = 1.
- `start` in 1: level request to run.
- `finish` out 1: run complete.

## Operation
- Pixel packing: 4 pixels per word, pixel x in byte x mod 4 (bits [7:0] = lowest x). 88 words per row, 288 rows, 25344 words per image.
- Word (row y, column c) is at base + y·88 + c.
- Sobel for an interior pixel (x in 1..350, y in 1..286):
  - Dx = (p[y-1][x+1] + 2p[y][x+1] + p[y+1][x+1]) − (p[y-1][x-1] + 2p[y][x-1] + p[y+1][x-1]).
  - Dy = (p[y+1][x-1] + 2p[y+1][x] + p[y+1][x+1]) − (p[y-1][x-1] + 2p[y-1][x] + p[y-1][x+1]).
  - Dx and Dy are 11-bit signed. Result = (|Dx| + |Dy|) >> 3; the 11-bit unsigned sum is at most 2040, so the result is bits [10:3] with no saturation needed.
- Border pixels (x = 0, x = 351, y = 0, y = 287) output 0x00.
- Window: 3 rows × 3 words (prev, cur, next), 288 bits, with out-of-image words held as zero.
- FSM states: IDLE, ZWR, PRE0–PRE3, FET0–FET3, WR, DONE.
- IDLE: all outputs 0. On `start` = 1, go to ZWR with y = 0, c = 0.
- ZWR (border rows y = 0 and y = 287): one cycle per word, writes 0x00000000 to DST_BASE + y·88 + c.
  - After c = 87: row 0 goes to PRE0 with y = 1; row 287 goes to DONE.
- PRE0–PRE3: load cur = column 0 of rows y−1, y, y+1; set prev = 0.
- FET0–FET3 (entered when c < 87): load next = column c+1.
  - FETk for k = 0..2 issues a read of row y−1+k.
  - FETk for k = 1..3 captures `dataR` from the read issued in the previous cycle.
  - FET3 has `en` = 0.
  - PRE0–PRE3 use the same pattern for column 0.
- When c = 87, next = 0 and the step goes directly to WR.
- WR (1 cycle): `en` = 1, `we` = 1, `dataW` = the 4 Sobel results for column c, with border columns forced to 0. Then shift prev←cur, cur←next and increment c.
  - After c = 87: if y < 286, go to PRE0 with y+1; if y = 286, go to ZWR with y = 287.
- DONE: `finish` = 1 while `start` = 1; on `start` = 0, go to IDLE the next cycle.
- Outputs depend on registered state only; there is no combinational path from `start` or `dataR`.

## Timing
- Memory contract:
  - Read: request (`en` = 1, `we` = 0, `addr`) in cycle t; `dataR` is sampled at the edge ending cycle t+1.
  - Write: commits at the edge ending the request cycle.
- Reset: next cycle, state = IDLE and `addr` = 0, `dataW` = 0, `en` = 0, `we` = 0, `finish` = 0. This also applies mid-run; the run is abandoned with memory partially written and no further accesses.
- Interior row: 4 + 87·4 + 88 = 440 cycles. Border row: 88 cycles.
- Run length:
  - `start` is sampled in IDLE at edge E0.
  - Cycles 1..126016 perform the work (2·88 + 286·440).
  - `finish` = 1 from cycle 126017.
- Totals per run: exactly 25344 writes and 75504 reads.
- Writes go in ascending address order.
- DST rows written never overlap the SRC region with the default parameters.

## Structure
- Package `acc_pkg` holds:
  - constants `IMG_W` = 352, `IMG_H` = 288, `WORDS_PER_ROW` = 88, `IMG_WORDS` = 25344;
  - the `acc_sobel` state enum type.
- Sub-module `sobel_px`: combinational, nine 8-bit inputs → one 8-bit result, instantiated 4×.

## Test plan
- Constant image of all 0x80: every DST word is 0x00000000; `finish` rises at cycle 126017; write count is 25344.
- Vertical step (x < 176 = 0x00, else 0xFF): every interior row has word 43 = 0x7F000000 and word 44 = 0x0000007F; all other words are 0.
- Horizontal step (y < 144 = 0x00, else 0xFF): rows 143 and 144 have word 0 = 0x7F7F7F00, words 1–86 = 0x7F7F7F7F, word 87 = 0x007F7F7F; all other rows are 0.
- Single impulse p[5][5] = 0xFF, rest 0: the 8 neighbours of (5,5) are 0x3F; (5,5) itself and all other pixels are 0.
- Reset pulsed at cycle 1000 of a run: next cycle `en`, `we`, `finish`, `addr` = 0. A fresh `start` then produces the full correct image.
- Handshake: `start` held high after `finish` keeps `finish` = 1. Dropping `start` gives IDLE with `finish` = 0 one cycle later. A second run produces an identical result.
